// File: rtl/game_flow_sequencer_pkg.sv
// Shared chess game-flow types: FSM states, display modes and side encoding.
package chess_pkg;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_ARM   = 3'd1,
    ST_WHITE = 3'd2,
    ST_BLACK = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_START   = 2'd0;
  localparam logic [1:0] MODE_BOARD   = 2'd1;
  localparam logic [1:0] MODE_TOP_WIN = 2'd2;
  localparam logic [1:0] MODE_BOT_WIN = 2'd3;

  localparam logic WHITE = 1'b1;
  localparam logic BLACK = 1'b0;

  // White sits at the bottom of the board, black at the top.
  function automatic logic [1:0] win_mode(input logic winner);
    return (winner == WHITE) ? MODE_BOT_WIN : MODE_TOP_WIN;
  endfunction

endpackage

// File: rtl/game_flow_sequencer_if.sv
// Handshake bundle between the game-flow sequencer and its neighbours.
interface game_flow_sequencer_if #(
  parameter int MOVE_WIDTH = 8
);
  logic                  startSwitch;
  logic                  playerTurn;
  logic [1:0]            checkmate;
  logic                  whiteTimeout;
  logic                  blackTimeout;
  logic                  frameEnd;
  logic [1:0]            displayMode;
  logic                  whiteTimerEn;
  logic                  blackTimerEn;
  logic                  timerReload;
  logic                  inputLock;
  logic                  bannerBlink;
  logic [MOVE_WIDTH-1:0] moveCount;

  // Drives the game inputs, observes the sequencer.
  modport master (
    output startSwitch, playerTurn, checkmate, whiteTimeout, blackTimeout, frameEnd,
    input  displayMode, whiteTimerEn, blackTimerEn, timerReload, inputLock,
           bannerBlink, moveCount
  );

  // The sequencer side.
  modport slave (
    input  startSwitch, playerTurn, checkmate, whiteTimeout, blackTimeout, frameEnd,
    output displayMode, whiteTimerEn, blackTimerEn, timerReload, inputLock,
           bannerBlink, moveCount
  );
endinterface

// File: rtl/game_flow_sequencer_sync.sv
// Parameterised multi-flop synchroniser for asynchronous switch/key inputs.
module SyncNbit #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;

  // Shift the raw input one stage deeper each cycle.
  always_comb stage_d = {stage_q[STAGES-2:0], d};

  // Synchroniser flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/game_flow_sequencer.sv
// Game-phase FSM: timer enables/reload, input lock, frame-aligned display mode,
// half-move counter and win-banner blink.
module game_flow_sequencer
  import chess_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int BLINK_FRAMES = 30,
  parameter int MOVE_WIDTH   = 8
) (
  input logic                  clock,
  input logic                  reset,
  game_flow_sequencer_if.slave bus
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic sw;

  state_e                state_q, state_d;
  logic [1:0]            pend_q, pend_d;
  logic [1:0]            disp_q, disp_d;
  logic                  wen_q, wen_d;
  logic                  ben_q, ben_d;
  logic                  reload_q, reload_d;
  logic                  lock_q, lock_d;
  logic                  blink_q, blink_d;
  logic [BW-1:0]         cnt_q, cnt_d;
  logic [MOVE_WIDTH-1:0] move_q, move_d;

  logic side, mover_to, other_to;

  SyncNbit #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sw_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.startSwitch),
    .q     (sw)
  );

  // Next-state, pending mode and registered-output computation.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    move_d   = move_q;
    reload_d = 1'b0;
    side     = (state_q == ST_WHITE) ? WHITE : BLACK;
    mover_to = (side == WHITE) ? bus.whiteTimeout : bus.blackTimeout;
    other_to = (side == WHITE) ? bus.blackTimeout : bus.whiteTimeout;

    case (state_q)
      ST_START: if (sw) begin
        state_d  = ST_ARM;
        reload_d = 1'b1;
        move_d   = '0;
        pend_d   = MODE_BOARD;
      end
      ST_ARM: if (bus.frameEnd) state_d = (bus.playerTurn == WHITE) ? ST_WHITE : ST_BLACK;
      ST_WHITE, ST_BLACK: begin
        if (bus.checkmate[0]) begin
          state_d = ST_OVER;
          pend_d  = win_mode(bus.checkmate[1]);
        end else if (mover_to) begin
          state_d = ST_OVER;
          pend_d  = win_mode(~side);
        end else if (other_to) begin
          state_d = ST_OVER;
          pend_d  = win_mode(side);
        end else if (bus.playerTurn != side) begin
          state_d = (bus.playerTurn == WHITE) ? ST_WHITE : ST_BLACK;
          move_d  = (move_q == '1) ? move_q : move_q + MOVE_WIDTH'(1);
        end
      end
      ST_OVER: ;
      default: state_d = ST_START;
    endcase

    // Switching off abandons the game from any phase and wins over everything.
    if (state_q != ST_START && !sw) begin
      state_d = ST_START;
      pend_d  = MODE_START;
    end

    wen_d  = (state_d == ST_WHITE);
    ben_d  = (state_d == ST_BLACK);
    lock_d = !(wen_d || ben_d);

    // Only frame boundaries expose the pending mode, so a frame never mixes content.
    disp_d = bus.frameEnd ? pend_q : disp_q;

    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (state_q != ST_OVER) begin
      cnt_d   = '0;
      blink_d = 1'b1;
    end else if (bus.frameEnd) begin
      if (cnt_q == BLINK_LAST) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + BW'(1);
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_START;
      pend_q   <= MODE_START;
      disp_q   <= MODE_START;
      wen_q    <= 1'b0;
      ben_q    <= 1'b0;
      reload_q <= 1'b0;
      lock_q   <= 1'b1;
      blink_q  <= 1'b1;
      cnt_q    <= '0;
      move_q   <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      disp_q   <= disp_d;
      wen_q    <= wen_d;
      ben_q    <= ben_d;
      reload_q <= reload_d;
      lock_q   <= lock_d;
      blink_q  <= blink_d;
      cnt_q    <= cnt_d;
      move_q   <= move_d;
    end
  end

  assign bus.displayMode  = disp_q;
  assign bus.whiteTimerEn = wen_q;
  assign bus.blackTimerEn = ben_q;
  assign bus.timerReload  = reload_q;
  assign bus.inputLock    = lock_q;
  assign bus.bannerBlink  = blink_q;
  assign bus.moveCount    = move_q;

endmodule

// File: tb/tb_game_flow_sequencer.sv
// Directed bench: DUT a uses default parameters, DUT b uses MOVE_WIDTH=2 and
// BLINK_FRAMES=2; both see identical stimulus.
module tb_game_flow_sequencer;

  logic clock = 1'b0;
  logic reset;
  logic start_sw, turn, wto, bto, fe;
  logic [1:0] mate;

  int vectors = 0;
  int errors  = 0;

  always #5 clock = ~clock;

  game_flow_sequencer_if #(.MOVE_WIDTH(8)) ifa ();
  game_flow_sequencer_if #(.MOVE_WIDTH(2)) ifb ();

  assign ifa.startSwitch  = start_sw;
  assign ifa.playerTurn   = turn;
  assign ifa.checkmate    = mate;
  assign ifa.whiteTimeout = wto;
  assign ifa.blackTimeout = bto;
  assign ifa.frameEnd     = fe;
  assign ifb.startSwitch  = start_sw;
  assign ifb.playerTurn   = turn;
  assign ifb.checkmate    = mate;
  assign ifb.whiteTimeout = wto;
  assign ifb.blackTimeout = bto;
  assign ifb.frameEnd     = fe;

  game_flow_sequencer #(.SYNC_STAGES(2), .BLINK_FRAMES(30), .MOVE_WIDTH(8)) dut_a (
    .clock (clock), .reset (reset), .bus (ifa)
  );
  game_flow_sequencer #(.SYNC_STAGES(2), .BLINK_FRAMES(2), .MOVE_WIDTH(2)) dut_b (
    .clock (clock), .reset (reset), .bus (ifb)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic frame();
    fe = 1'b1; tick(); fe = 1'b0; tick();
  endtask

  task automatic test_reset();
    start_sw = 0; turn = 1; wto = 0; bto = 0; fe = 0; mate = 2'b00;
    reset = 1'b1;
    tick(); tick();
    vectors++; if (ifa.displayMode !== 2'd0) begin errors++; $display("FAIL rst_mode: got %0d exp 0", ifa.displayMode); end
    vectors++; if (ifa.whiteTimerEn !== 1'b0 || ifa.blackTimerEn !== 1'b0) begin errors++; $display("FAIL rst_en: got w%0d b%0d exp 0 0", ifa.whiteTimerEn, ifa.blackTimerEn); end
    vectors++; if (ifa.timerReload !== 1'b0) begin errors++; $display("FAIL rst_reload: got %0d exp 0", ifa.timerReload); end
    vectors++; if (ifa.inputLock !== 1'b1) begin errors++; $display("FAIL rst_lock: got %0d exp 1", ifa.inputLock); end
    vectors++; if (ifa.bannerBlink !== 1'b1) begin errors++; $display("FAIL rst_blink: got %0d exp 1", ifa.bannerBlink); end
    vectors++; if (ifa.moveCount !== 8'd0 || ifb.moveCount !== 2'd0) begin errors++; $display("FAIL rst_move: got %0d/%0d exp 0/0", ifa.moveCount, ifb.moveCount); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_start();
    int rl = 0;
    start_sw = 1; turn = 1;
    tick(); rl += int'(ifa.timerReload);
    tick(); rl += int'(ifa.timerReload);
    tick(); rl += int'(ifa.timerReload);
    vectors++; if (ifa.timerReload !== 1'b1) begin errors++; $display("FAIL start_latency: reload got %0d exp 1 after 3 cycles", ifa.timerReload); end
    repeat (3) begin tick(); rl += int'(ifa.timerReload); end
    vectors++; if (rl != 1) begin errors++; $display("FAIL start_reload_count: got %0d exp 1", rl); end
    vectors++; if (ifa.displayMode !== 2'd0 || ifa.inputLock !== 1'b1) begin errors++; $display("FAIL arm_hold: mode %0d lock %0d exp 0 1", ifa.displayMode, ifa.inputLock); end
    frame();
    vectors++; if (ifa.displayMode !== 2'd1) begin errors++; $display("FAIL start_mode: got %0d exp 1", ifa.displayMode); end
    vectors++; if (ifa.whiteTimerEn !== 1'b1 || ifa.blackTimerEn !== 1'b0 || ifa.inputLock !== 1'b0) begin errors++; $display("FAIL start_white: w%0d b%0d lock%0d exp 1 0 0", ifa.whiteTimerEn, ifa.blackTimerEn, ifa.inputLock); end
  endtask

  task automatic test_toggle();
    for (int i = 1; i <= 5; i++) begin
      turn = ~turn;
      tick();
      vectors++; if (ifa.whiteTimerEn !== turn || ifa.blackTimerEn !== ~turn) begin errors++; $display("FAIL toggle_en%0d: w%0d b%0d exp w%0d", i, ifa.whiteTimerEn, ifa.blackTimerEn, turn); end
      vectors++; if (ifa.moveCount !== 8'(i)) begin errors++; $display("FAIL toggle_move%0d: got %0d exp %0d", i, ifa.moveCount, i); end
    end
    vectors++; if (ifb.moveCount !== 2'd3) begin errors++; $display("FAIL move_saturate: got %0d exp 3", ifb.moveCount); end
    turn = 1;
    tick();
    vectors++; if (ifa.whiteTimerEn !== 1'b1 || ifa.moveCount !== 8'd6) begin errors++; $display("FAIL back_to_white: w%0d move %0d exp 1 6", ifa.whiteTimerEn, ifa.moveCount); end
  endtask

  task automatic test_dual_timeout();
    wto = 1; bto = 1;
    tick();
    wto = 0; bto = 0;
    vectors++; if (ifa.whiteTimerEn !== 1'b0 || ifa.blackTimerEn !== 1'b0 || ifa.inputLock !== 1'b1) begin errors++; $display("FAIL timeout_over: w%0d b%0d lock%0d exp 0 0 1", ifa.whiteTimerEn, ifa.blackTimerEn, ifa.inputLock); end
    vectors++; if (ifa.displayMode !== 2'd1) begin errors++; $display("FAIL timeout_mode_hold: got %0d exp 1", ifa.displayMode); end
    frame();
    vectors++; if (ifa.displayMode !== 2'd2 || ifb.displayMode !== 2'd2) begin errors++; $display("FAIL timeout_mode: got %0d/%0d exp 2", ifa.displayMode, ifb.displayMode); end
    vectors++; if (ifa.moveCount !== 8'd6) begin errors++; $display("FAIL timeout_move: got %0d exp 6", ifa.moveCount); end
  endtask

  task automatic test_blink();
    int toggles = 0;
    logic prev;
    prev = ifb.bannerBlink;
    repeat (6) begin
      frame();
      if (ifb.bannerBlink !== prev) toggles++;
      prev = ifb.bannerBlink;
    end
    vectors++; if (toggles != 3) begin errors++; $display("FAIL blink_toggles: got %0d exp 3", toggles); end
    vectors++; if (ifb.bannerBlink !== 1'b0) begin errors++; $display("FAIL blink_final: got %0d exp 0", ifb.bannerBlink); end
    vectors++; if (ifa.bannerBlink !== 1'b1) begin errors++; $display("FAIL blink_slow: got %0d exp 1", ifa.bannerBlink); end
  endtask

  task automatic test_checkmate();
    start_sw = 0;
    repeat (3) tick();
    vectors++; if (ifa.displayMode !== 2'd2 || ifa.inputLock !== 1'b1) begin errors++; $display("FAIL stop_hold: mode %0d lock %0d exp 2 1", ifa.displayMode, ifa.inputLock); end
    frame();
    vectors++; if (ifa.displayMode !== 2'd0 || ifb.bannerBlink !== 1'b1) begin errors++; $display("FAIL stop_mode: mode %0d blink %0d exp 0 1", ifa.displayMode, ifb.bannerBlink); end
    start_sw = 1; turn = 1;
    tick(); tick();
    fe = 1; tick(); fe = 0;
    vectors++; if (ifa.timerReload !== 1'b1 || ifa.moveCount !== 8'd0) begin errors++; $display("FAIL restart: reload %0d move %0d exp 1 0", ifa.timerReload, ifa.moveCount); end
    vectors++; if (ifa.displayMode !== 2'd0) begin errors++; $display("FAIL pend_same_cycle: got %0d exp 0", ifa.displayMode); end
    frame();
    vectors++; if (ifa.displayMode !== 2'd1 || ifa.whiteTimerEn !== 1'b1) begin errors++; $display("FAIL restart_white: mode %0d w%0d exp 1 1", ifa.displayMode, ifa.whiteTimerEn); end
    mate = 2'b11; bto = 1;
    tick();
    mate = 2'b00; bto = 0;
    vectors++; if (ifa.whiteTimerEn !== 1'b0 || ifa.blackTimerEn !== 1'b0 || ifa.inputLock !== 1'b1) begin errors++; $display("FAIL mate_over: w%0d b%0d lock%0d exp 0 0 1", ifa.whiteTimerEn, ifa.blackTimerEn, ifa.inputLock); end
    frame();
    vectors++; if (ifa.displayMode !== 2'd3) begin errors++; $display("FAIL mate_mode: got %0d exp 3", ifa.displayMode); end
  endtask

  task automatic test_sw_off_midgame();
    start_sw = 0;
    repeat (3) tick();
    frame();
    start_sw = 1; turn = 0;
    repeat (3) tick();
    frame();
    vectors++; if (ifa.blackTimerEn !== 1'b1 || ifa.whiteTimerEn !== 1'b0) begin errors++; $display("FAIL start_black: w%0d b%0d exp 0 1", ifa.whiteTimerEn, ifa.blackTimerEn); end
    start_sw = 0;
    tick(); tick();
    vectors++; if (ifa.blackTimerEn !== 1'b1) begin errors++; $display("FAIL off_latency: b%0d exp 1", ifa.blackTimerEn); end
    tick();
    vectors++; if (ifa.blackTimerEn !== 1'b0 || ifa.inputLock !== 1'b1) begin errors++; $display("FAIL off_start: b%0d lock%0d exp 0 1", ifa.blackTimerEn, ifa.inputLock); end
    vectors++; if (ifa.displayMode !== 2'd1) begin errors++; $display("FAIL off_mode_hold: got %0d exp 1", ifa.displayMode); end
    frame();
    vectors++; if (ifa.displayMode !== 2'd0) begin errors++; $display("FAIL off_mode: got %0d exp 0", ifa.displayMode); end
  endtask

  task automatic test_reset_pending();
    int rl = 0;
    start_sw = 1;
    tick(); tick();
    reset = 1'b1;
    #1;
    rl += int'(ifa.timerReload);
    repeat (3) begin tick(); rl += int'(ifa.timerReload); end
    start_sw = 0;
    tick();
    reset = 1'b0;
    repeat (5) begin tick(); rl += int'(ifa.timerReload); end
    vectors++; if (rl != 0) begin errors++; $display("FAIL reset_reload: got %0d pulses exp 0", rl); end
    vectors++; if (ifa.inputLock !== 1'b1 || ifa.displayMode !== 2'd0) begin errors++; $display("FAIL reset_state: lock%0d mode %0d exp 1 0", ifa.inputLock, ifa.displayMode); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_toggle();
    test_dual_timeout();
    test_blink();
    test_checkmate();
    test_sw_off_midgame();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
